usb_gpx_conditioner: RTL
========================

# usb_gpx_conditioner

Input conditioning stage for the MAX3421E GPX pin. It sits directly upstream of the GPX PIO and drives that PIO's `in_port` with a synchronized, glitch-filtered level. It also captures rising and falling edges, counts rising edges, and raises a maskable interrupt. All of these are exposed on a small Avalon-MM slave for the NIOS USB driver.

## Interface
- `FILTER_CYCLES`, default 4: consecutive synchronized samples a new level must hold before it is accepted. Legal range 1..255. The counter width is derived internally with `$clog2`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset. One clock domain only.
- `gpx_pin`  in  1  raw GPX pin, asynchronous to `clk`.
- `gpx_out`  out  1  filtered level; feeds the GPX PIO `in_port`.
- `address`  in  2  Avalon word address.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, registered.
- `irq`  out  1  level interrupt, active high.

## Operation
- **Synchronizer:** `gpx_pin` passes through two flops, `sync0` then `sync1`. `sync1` is the only internal consumer of the pin.
- **Filter counter `cnt`:**
  - If `sync1 == gpx_out`, `cnt` is set to 0.
  - Otherwise, if `cnt == FILTER_CYCLES-1`, then `gpx_out` takes the value of `sync1` and `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - If `sync1` reverts before acceptance, `cnt` returns to 0 and `gpx_out` is unchanged.
- **Edge capture `ecap[1:0]`:**
  - `ecap[0]` sets on the edge where `gpx_out` goes 0→1.
  - `ecap[1]` sets on the edge where `gpx_out` goes 1→0.
  - Both bits are sticky. They are cleared by writing 1 to address 3; writing 0 has no effect.
  - If a set and a clear of the same bit occur in one cycle, the set wins.
- **Rise counter `rcnt[15:0]`:** increments on every accepted 0→1 transition and wraps from 0xFFFF to 0x0000. Any write to address 1 clears it. If a write and an increment occur in the same cycle, the result is 0.
- **Interrupt mask `imask[1:0]`:** written at address 2 from `writedata[1:0]`.
- **`irq`:** `|(ecap & imask)`, decoded combinationally from flops.
- **Register map** (unused bits read 0):
  - 0, read-only: bit0 = `gpx_out`, bit1 = `sync1`.
  - 1, read/write-clear: `rcnt` in bits [15:0].
  - 2, read/write: `imask` in bits [1:0].
  - 3, read/W1C: `ecap` in bits [1:0].
  - Writes to address 0 are ignored.
- **`readdata`:** updated every clock from the mux of `address`. There is no read strobe and reads have no side effects.
- **Reset values:** every register, including `gpx_out`, `readdata` and `irq`, is 0.
  - Reset asserted mid-filter discards the pending `cnt`.
  - If the pin is high at reset release, the block reports a rising edge after normal latency: `ecap[0]` sets and `rcnt` becomes 1.

## Timing
- Pin to `gpx_out`, with the filter enabled: `gpx_out` changes on the (`FILTER_CYCLES`+2)th rising edge. Count the edge that first samples the new level into `sync0` as edge 1. With the default of 4, that is edge 6.
- A pulse lasting fewer than `FILTER_CYCLES` `sync1` samples is always rejected.
- `ecap`, `rcnt` and `irq` update on the same edge as `gpx_out`.
- Register write takes effect on the edge that samples `write`.
- Read latency is 1: `readdata` reflects state at the edge after `address` is presented.
- Maximum accepted toggle rate is one transition per `FILTER_CYCLES` cycles.

## Configuration
- `USB_GPX_FILTER_EN` defined: the filter counter is built as described above.
- `USB_GPX_FILTER_EN` undefined:
  - No counter is built and `FILTER_CYCLES` is ignored.
  - `gpx_out` takes `sync1` every clock, so any level change appears on edge 3.
  - Edge capture, `rcnt`, `irq` and the register map are unchanged.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle. All outputs must be 0 immediately, and `readdata` must be 0 at every address after release with the pin low.
- **Latency:** with `FILTER_CYCLES`=4, raise `gpx_pin` before edge 1. `gpx_out`, `ecap[0]` and `rcnt`=1 must all appear after edge 6, and not after edge 5.
- **Glitch reject:** pulse `gpx_pin` high for 3 cycles. `gpx_out`, `ecap` and `rcnt` stay 0. Repeat with a 4-cycle pulse: a rise is accepted, followed by a fall.
- **IRQ and W1C:**
  - Set `imask`=2'b10, then drive a rising edge: `irq` stays 0.
  - Drive a falling edge: `irq`=1.
  - Write 2'b10 to address 3: `irq`=0 and `ecap`=2'b01.
  - Write the clear in the same cycle as a new fall: `ecap[1]` stays 1.
- **Counter wrap:** preload to 0xFFFF via edges (or force in sim); one more rise reads 0x0000. A write to address 1 coincident with a rise reads 0.
- **Macro off:** build without `USB_GPX_FILTER_EN`. A 1-cycle pin pulse passes through `gpx_out` on edge 3, sets both `ecap` bits, and leaves `rcnt`=1.

Source files
------------

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner: synchronizer, optional glitch filter, edge capture,
// rise counter, maskable irq and a 4-word Avalon-MM register slave.
//
// Ports:
//   clk, reset       system clock, async active-high reset
//   gpx_pin          raw MAX3421E GPX pin (async to clk)
//   gpx_out          filtered level, feeds the GPX PIO in_port
//   address, write,
//   writedata        Avalon-MM slave write side
//   readdata         registered read data (1-cycle latency)
//   irq              level interrupt, |(ecap & imask)
//
// Config macro: USB_GPX_FILTER_EN builds the FILTER_CYCLES debounce counter;
// without it gpx_out follows the synchronized pin every clock.
//
// Register map:
//   0 RO  {gpx_out, sync1} in bits [1:0] as bit0=gpx_out, bit1=sync1
//   1 RW  rcnt[15:0], any write clears
//   2 RW  imask[1:0]
//   3 W1C ecap[1:0] (bit0 rise, bit1 fall)

module usb_gpx_conditioner #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  output logic        gpx_out,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_cfg
    $error("usb_gpx_conditioner: FILTER_CYCLES out of range 1..255");
  end

  logic        sync0_q, sync1_q;
  logic        out_q, out_d;
  logic [1:0]  ecap_q, ecap_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [1:0]  imask_q, imask_d;
  logic [31:0] rdata_q, rdata_d;

  logic        rise, fall;
  logic        wr_rcnt, wr_imask, wr_ecap;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  // Two-flop synchronizer; sync1 is the only consumer of the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= gpx_pin;
      sync1_q <= sync0_q;
    end
  end

`ifdef USB_GPX_FILTER_EN
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A differing level must persist FILTER_CYCLES samples; any revert
  // (sync1 == out) drops the pending count.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync1_q != out_q) begin
      if (cnt_q == CNT_MAX) begin
        out_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    out_d = sync1_q;
  end
`endif

  // Edges are taken from the next-state level so ecap/rcnt/irq move on
  // the same clock edge as gpx_out.
  assign rise = out_d & ~out_q;
  assign fall = ~out_d & out_q;

  assign wr_rcnt  = write && (address == 2'd1);
  assign wr_imask = write && (address == 2'd2);
  assign wr_ecap  = write && (address == 2'd3);

  always_comb begin
    ecap_d = ecap_q;
    if (wr_ecap) begin
      ecap_d = ecap_q & ~writedata[1:0];
    end
    // Set beats a same-cycle W1C.
    ecap_d = ecap_d | {fall, rise};
  end

  always_comb begin
    rcnt_d = rcnt_q;
    if (wr_rcnt) begin
      rcnt_d = '0;
    end else if (rise) begin
      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_comb begin
    imask_d = imask_q;
    if (wr_imask) begin
      imask_d = writedata[1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      2'd0:    rdata_d = {30'd0, sync1_q, out_q};
      2'd1:    rdata_d = {16'd0, rcnt_q};
      2'd2:    rdata_d = {30'd0, imask_q};
      default: rdata_d = {30'd0, ecap_q};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= 1'b0;
      ecap_q  <= '0;
      rcnt_q  <= '0;
      imask_q <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      ecap_q  <= ecap_d;
      rcnt_q  <= rcnt_d;
      imask_q <= imask_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpx_out  = out_q;
  assign readdata = rdata_q;
  assign irq      = |(ecap_q & imask_q);

endmodule
